// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_pkg
// Purpose  : Shared constants and types for the write-back arbiter slice:
//            load-type encodings, datapath widths and arbiter state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  // Load-type encodings; 5..7 decode as a full-word load.
  localparam logic [2:0] LT_LW  = 3'd0;
  localparam logic [2:0] LT_LB  = 3'd1;
  localparam logic [2:0] LT_LBU = 3'd2;
  localparam logic [2:0] LT_LH  = 3'd3;
  localparam logic [2:0] LT_LHU = 3'd4;

  // IDLE: buffer empty; HELD: LU result parked; FORCE: one-cycle stall to drain it.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HELD  = 2'd1,
    ST_FORCE = 2'd2
  } wb_state_e;

endpackage : wb_pkg
`default_nettype wire

// File: rtl/wb_load_align.sv
`default_nettype none
// ============================================================================
// Module   : wb_load_align
// Purpose  : Big-endian byte/halfword extraction from a memory word with
//            sign or zero extension; full-word loads pass through unchanged.
// Revision : 1.0 - initial release
// ============================================================================
module wb_load_align
  import wb_pkg::*;
(
  input  logic [2:0]        load_type,
  input  logic [1:0]        byte_offset,
  input  logic [DATA_W-1:0] word,
  output logic [DATA_W-1:0] data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Pick the addressed byte/halfword (offset 0 is the most significant lane).
  always_comb begin
    sel_byte = word[31:24];
    case (byte_offset)
      2'd0:    sel_byte = word[31:24];
      2'd1:    sel_byte = word[23:16];
      2'd2:    sel_byte = word[15:8];
      default: sel_byte = word[7:0];
    endcase
    sel_half = byte_offset[1] ? word[15:0] : word[31:16];
  end

  // Extend the selected lane according to the load type.
  always_comb begin
    data = word;
    case (load_type)
      LT_LB:   data = {{24{sel_byte[7]}}, sel_byte};
      LT_LBU:  data = {24'd0, sel_byte};
      LT_LH:   data = {{16{sel_half[15]}}, sel_half};
      LT_LHU:  data = {16'd0, sel_half};
      default: data = word;
    endcase
  end

endmodule : wb_load_align
`default_nettype wire

// File: rtl/wb_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_write_arbiter
// Purpose  : Drives the register-file write port from the MEM/WB pipeline and
//            a long-latency unit, with a one-entry LU holding buffer and a
//            one-cycle anti-starvation stall.
// Options  : WB_PENDING_HAZARD_EN adds Lu_Pending_Valid / Lu_Pending_Dest.
// Revision : 1.0 - initial release
// ============================================================================
module wb_write_arbiter
  import wb_pkg::*;
#(
  parameter int MAX_DEFER = 4,
  parameter int DEFER_W   = 4
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  Pipe_Valid_MEM,
  input  logic [REG_ADDR_W-1:0] Pipe_Dest_MEM,
  input  logic [DATA_W-1:0]     Pipe_Data_MEM,
  input  logic                  Pipe_MemToReg_MEM,
  input  logic [2:0]            Pipe_LoadType_MEM,
  input  logic [1:0]            Pipe_ByteOffset_MEM,
  input  logic [DATA_W-1:0]     Mem_Read_Data_MEM,
  input  logic                  Lu_Valid,
  input  logic [REG_ADDR_W-1:0] Lu_Dest,
  input  logic [DATA_W-1:0]     Lu_Data,
  output logic                  Lu_Ready,
  output logic                  Stall_WB,
  output logic                  RegWrite_WB,
  output logic [REG_ADDR_W-1:0] Write_Register_WB,
  output logic [DATA_W-1:0]     Write_Data_WB
`ifdef WB_PENDING_HAZARD_EN
  ,
  output logic                  Lu_Pending_Valid,
  output logic [REG_ADDR_W-1:0] Lu_Pending_Dest
`endif
);

  localparam logic [DEFER_W-1:0] MAX_CNT = DEFER_W'(MAX_DEFER);
  localparam logic [DEFER_W-1:0] ONE_CNT = DEFER_W'(1);

  wb_state_e              state, state_next;
  logic [DEFER_W-1:0]     defer_cnt, cnt_next, cnt_inc;
  logic [REG_ADDR_W-1:0]  buf_dest, buf_dest_next;
  logic [DATA_W-1:0]      buf_data, buf_data_next;
  logic                   wr_en_next;
  logic [REG_ADDR_W-1:0]  wr_addr_next;
  logic [DATA_W-1:0]      wr_data_next;
  logic [DATA_W-1:0]      load_data, pipe_result;
  logic                   pipe_take, pipe_wr, lu_wr;

  wb_load_align u_align (
    .load_type   (Pipe_LoadType_MEM),
    .byte_offset (Pipe_ByteOffset_MEM),
    .word        (Mem_Read_Data_MEM),
    .data        (load_data)
  );

  assign pipe_result = Pipe_MemToReg_MEM ? load_data : Pipe_Data_MEM;
  // Pipeline inputs are frozen upstream while the drain stall is up.
  assign pipe_take   = Pipe_Valid_MEM && (state != ST_FORCE);
  // Register-0 results are consumed here and never reach the port or buffer.
  assign pipe_wr     = pipe_take && (Pipe_Dest_MEM != '0);
  assign lu_wr       = Lu_Valid && Lu_Ready && (Lu_Dest != '0);
  assign cnt_inc     = defer_cnt + ONE_CNT;

  // Next-state, buffer and write-port selection; pipeline always wins the port.
  always_comb begin
    state_next    = state;
    cnt_next      = defer_cnt;
    buf_dest_next = buf_dest;
    buf_data_next = buf_data;
    wr_en_next    = 1'b0;
    wr_addr_next  = '0;
    wr_data_next  = '0;
    case (state)
      ST_IDLE: begin
        if (pipe_wr) begin
          wr_en_next   = 1'b1;
          wr_addr_next = Pipe_Dest_MEM;
          wr_data_next = pipe_result;
          if (lu_wr) begin
            buf_dest_next = Lu_Dest;
            buf_data_next = Lu_Data;
            cnt_next      = ONE_CNT;
            state_next    = (MAX_CNT == ONE_CNT) ? ST_FORCE : ST_HELD;
          end
        end else if (lu_wr) begin
          wr_en_next   = 1'b1;
          wr_addr_next = Lu_Dest;
          wr_data_next = Lu_Data;
        end
      end
      ST_HELD: begin
        if (pipe_wr) begin
          wr_en_next   = 1'b1;
          wr_addr_next = Pipe_Dest_MEM;
          wr_data_next = pipe_result;
          cnt_next     = cnt_inc;
          if (cnt_inc == MAX_CNT) state_next = ST_FORCE;
        end else begin
          wr_en_next   = 1'b1;
          wr_addr_next = buf_dest;
          wr_data_next = buf_data;
          cnt_next     = '0;
          state_next   = ST_IDLE;
        end
      end
      ST_FORCE: begin
        wr_en_next   = 1'b1;
        wr_addr_next = buf_dest;
        wr_data_next = buf_data;
        cnt_next     = '0;
        state_next   = ST_IDLE;
      end
      default: begin
        cnt_next   = '0;
        state_next = ST_IDLE;
      end
    endcase
  end

  // State, buffer and registered outputs; reset drops any buffered LU result.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state             <= ST_IDLE;
      defer_cnt         <= '0;
      buf_dest          <= '0;
      buf_data          <= '0;
      RegWrite_WB       <= 1'b0;
      Write_Register_WB <= '0;
      Write_Data_WB     <= '0;
      Stall_WB          <= 1'b0;
      Lu_Ready          <= 1'b1;
    end else begin
      state             <= state_next;
      defer_cnt         <= cnt_next;
      buf_dest          <= buf_dest_next;
      buf_data          <= buf_data_next;
      RegWrite_WB       <= wr_en_next;
      Write_Register_WB <= wr_addr_next;
      Write_Data_WB     <= wr_data_next;
      Stall_WB          <= (state_next == ST_FORCE);
      Lu_Ready          <= (state_next == ST_IDLE);
    end
  end

`ifdef WB_PENDING_HAZARD_EN
  assign Lu_Pending_Valid = (state != ST_IDLE) && (buf_dest != '0);
  assign Lu_Pending_Dest  = Lu_Pending_Valid ? buf_dest : '0;
`endif

endmodule : wb_write_arbiter
`default_nettype wire

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Write-back stage block that drives the register file's single write port (Write_Register_WB / Write_Data_WB / RegWrite_WB); the register file commits on the negedge of Clk.
- Merges two result producers: the main pipeline (MEM/WB) and a long-latency unit (LU, e.g. divider).
- Performs load-data byte/halfword extraction and sign/zero extension.
- Arbitrates the single write port with a one-entry LU holding buffer and an anti-starvation stall.

Parameters:
- MAX_DEFER, 4: consecutive cycles a buffered LU result may be deferred before Stall_WB is forced; range 1..15.
- DEFER_W, 4: width of the defer counter.

Ports:
- Clk  in  1  clock; all state updates on posedge.
- Reset_n  in  1  synchronous, active-low reset.
- Pipe_Valid_MEM  in  1  pipeline result present this cycle.
- Pipe_Dest_MEM  in  5  destination register.
- Pipe_Data_MEM  in  32  ALU result.
- Pipe_MemToReg_MEM  in  1  1: write load data; 0: write ALU result.
- Pipe_LoadType_MEM  in  3  0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU; 5-7 treated as LW.
- Pipe_ByteOffset_MEM  in  2  address bits [1:0] of the load.
- Mem_Read_Data_MEM  in  32  raw data-memory word.
- Lu_Valid  in  1  LU result offered.
- Lu_Dest  in  5  LU destination register.
- Lu_Data  in  32  LU result.
- Lu_Ready  out  1  LU result accepted when Lu_Valid & Lu_Ready at posedge.
- Stall_WB  out  1  upstream must hold Pipe_* stable; Pipe_* is not sampled this cycle.
- RegWrite_WB  out  1  register-file write enable.
- Write_Register_WB  out  5  register-file write address.
- Write_Data_WB  out  32  register-file write data.

Behaviour:
- Reset (Reset_n=0 at posedge): all of the following take effect.
  - Outputs: RegWrite_WB=0, Write_Register_WB=0, Write_Data_WB=0, Stall_WB=0, Lu_Ready=1.
  - State: buffer empty, defer count 0, state IDLE.
  - A reset mid-operation discards the buffered LU result.
- Latency: write outputs are registered; a sampled result appears one cycle later for exactly one cycle.
- Load extraction is big-endian.
  - Byte: offset 0 -> [31:24], 1 -> [23:16], 2 -> [15:8], 3 -> [7:0].
  - Halfword: offset[1]=0 -> [31:16], 1 -> [15:0]; offset[0] is ignored.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word and ignores the offset.
- Destination 0: any result targeting register 0 is consumed and produces RegWrite_WB=0.
  - It never occupies the port or the buffer.
- States:
  - IDLE (buffer empty), Lu_Ready=1.
    - LU handshake with no pipeline write this cycle: write the LU result next cycle; stay IDLE.
    - LU handshake with a pipeline write this cycle: pipeline wins; LU result goes to the buffer; -> HELD with count 1.
  - HELD (buffer full), Lu_Ready=0.
    - No pipeline write: retire the buffer; -> IDLE.
    - Pipeline write: pipeline wins; count increments.
    - When count reaches MAX_DEFER: -> FORCE.
  - FORCE: Stall_WB=1 for exactly one cycle, Lu_Ready=0.
    - The buffer retires; Pipe_* is ignored; -> IDLE next cycle with Stall_WB=0.
- Lu_Ready is registered from next state, so it is never 1 while the buffer is full.
- A pipeline write and a buffered entry to the same register: pipeline writes first, buffer later.
  - Program order is the upstream issue logic's responsibility.

Optional Feature:
- Macro: WB_PENDING_HAZARD_EN.
- Defined: adds outputs Lu_Pending_Valid (1) and Lu_Pending_Dest (5).
  - Both are combinational from the buffer: valid=1 in HELD/FORCE with a nonzero dest.
  - ID uses them to interlock reads of a deferred LU destination.
  - Both are 0 after reset.
- Undefined: the ports are absent; behaviour is otherwise identical.

Decomposition:
- Shared package wb_pkg:
  - Load-type constants LT_LW..LT_LHU.
  - Arbiter state enum (IDLE, HELD, FORCE).
  - REG_ADDR_W=5, DATA_W=32.
- One sub-module: wb_load_align (combinational extract/extend from type, offset and word).

Test Plan:
- Reset: hold Reset_n=0 for 2 cycles with Pipe_Valid_MEM=1 -> RegWrite_WB=0, Lu_Ready=1, Stall_WB=0 throughout.
- Loads from word 0x80FF7F01:
  - LB offset 0 -> 0xFFFFFF80.
  - LBU offset 0 -> 0x00000080.
  - LH offset 2 -> 0x00007F01.
  - LHU offset 0 -> 0x000080FF.
  - LW -> 0x80FF7F01.
  - Each with dest 5, written one cycle after sampling.
- Collision: Pipe (dest 3, 0x11) and LU (dest 4, 0x22) in the same cycle, then pipeline idle.
  - Writes $3=0x11, then $4=0x22 on consecutive cycles.
  - Lu_Ready=0 for one cycle.
- Starvation with MAX_DEFER=4: buffered LU (dest 7) plus continuous pipeline writes.
  - Stall_WB=1 for one cycle after 4 deferrals; $7 is written that cycle.
  - The held pipeline result is written next cycle.
- Register 0: Pipe dest 0 and LU dest 0 in the same cycle -> no RegWrite_WB pulse, Lu_Ready stays 1, buffer stays empty.
- Mid-operation reset: reset while in HELD -> buffer discarded, no write of the held value, Lu_Pending_Valid=0 (when enabled).
